// File: rtl/diag_i2c_pkg.sv
// diag_i2c_pkg: shared constants and FSM states for the diagnostic I2C page/value link
package diag_i2c_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;
    localparam logic [6:0] DIAG_I2C_ADDR    = 7'h5D;
    localparam int         DIAG_FRAME_BYTES = 3;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchronizer plus FILT_LEN-sample agreement filter with edge flags
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic ext_reset,
    input  logic i_pad,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] r_sync;
    logic [2:0] r_cnt;
    logic       r_lvl, r_rise, r_fall;
    logic       w_upd;
    assign w_upd  = (r_sync[1] != r_lvl) && (r_cnt == 3'(FILT_LEN - 1));
    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_lvl  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pad};
            r_rise <= w_upd && r_sync[1];
            r_fall <= w_upd && !r_sync[1];
            r_cnt  <= (r_sync[1] == r_lvl || w_upd) ? 3'd0 : r_cnt + 3'd1;
            if (w_upd)
                r_lvl <= r_sync[1];
        end
    end
endmodule

// File: rtl/i2c_diag_target.sv
// i2c_diag_target: I2C write-only target decoding 3-byte page/value diag frames
module i2c_diag_target
    import diag_i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = DIAG_I2C_ADDR,
    parameter int         FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        ext_reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        rx_valid,
    output logic [7:0]  rx_page,
    output logic [15:0] rx_value,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);
    localparam logic [1:0] NB = 2'(DIAG_FRAME_BYTES);
    state_t          r_state, w_next;
    logic [6:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic [1:0]      r_idx;
    logic [2:0][7:0] r_buf;
    logic            r_overlong, r_nack, r_slot, r_sda_oe, r_valid, r_err;
    logic [7:0]      r_page;
    logic [15:0]     r_value, r_frame_cnt, r_err_cnt;
    logic            w_scl, w_scl_rise, w_scl_fall, w_sda, w_sda_rise, w_sda_fall;
    logic            w_start, w_stop, w_last, w_in_data, w_addressed, w_partial, w_good, w_ack_st;
    logic            w_ok, w_err;
    logic [7:0]      w_shift;
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk), .ext_reset(ext_reset), .i_pad(scl_in),
        .o_lvl(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk), .ext_reset(ext_reset), .i_pad(sda_in),
        .o_lvl(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );
    assign w_start     = w_sda_fall && w_scl;
    assign w_stop      = w_sda_rise && w_scl;
    assign w_shift     = {r_shift, w_sda};
    assign w_last      = w_scl_rise && (r_bitcnt == 3'd7);
    assign w_in_data   = (r_state == ST_DATA) || (r_state == ST_DATA_ACK);
    assign w_addressed = w_in_data || (r_state == ST_ADDR_ACK);
    assign w_ack_st    = (r_state == ST_ADDR_ACK) || (r_state == ST_DATA_ACK);
    // the SCL rise that precedes any STOP/Sr is always counted as one bit, so a byte is partial only past it
    assign w_partial   = r_bitcnt > 3'd1;
    assign w_good      = w_in_data && (r_idx == NB) && !r_overlong && !w_partial;
    assign sda_oe      = r_sda_oe;
    assign rx_valid    = r_valid;
    assign frame_err   = r_err;
    assign rx_page     = r_page;
    assign rx_value    = r_value;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;
    assign busy        = r_state != ST_IDLE;
    always_comb begin
        w_next = r_state;
        w_ok   = 1'b0;
        w_err  = 1'b0;
        if (w_stop) begin
            w_next = ST_IDLE;
            w_ok   = w_addressed && w_good;
            w_err  = w_addressed && !w_good;
        end else if (w_start) begin
            w_next = ST_ADDR;
            w_err  = w_in_data && (r_idx != 2'd0 || w_partial);
        end else begin
            case (r_state)
                ST_ADDR:     if (w_last) w_next = (w_shift == {I2C_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                ST_DATA:     if (w_last) w_next = ST_DATA_ACK;
                ST_ADDR_ACK,
                ST_DATA_ACK: if (w_scl_fall && r_slot) w_next = ST_DATA;
                default:     w_next = r_state;
            endcase
        end
    end
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_idx       <= '0;
            r_buf       <= '0;
            r_overlong  <= 1'b0;
            r_nack      <= 1'b0;
            r_slot      <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_page      <= '0;
            r_value     <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_ok;
            r_err   <= w_err;
            if (w_ok) begin
                r_page      <= r_buf[0];
                r_value     <= {r_buf[1], r_buf[2]};
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (w_start || w_stop) begin
                r_bitcnt   <= '0;
                r_idx      <= '0;
                r_overlong <= 1'b0;
                r_nack     <= 1'b0;
                r_slot     <= 1'b0;
                r_sda_oe   <= 1'b0;
            end else begin
                if (w_scl_rise && (r_state == ST_ADDR || r_state == ST_DATA)) begin
                    r_shift  <= w_shift[6:0];
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                if (r_state == ST_DATA && w_last) begin
                    r_nack <= r_idx == NB;
                    if (r_idx == NB)
                        r_overlong <= 1'b1;
                    else begin
                        r_buf[r_idx] <= w_shift;
                        r_idx        <= r_idx + 2'd1;
                    end
                end
                if (w_ack_st && w_scl_fall) begin
                    r_slot   <= !r_slot;
                    r_sda_oe <= !r_slot && !(r_state == ST_DATA_ACK && r_nack);
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_diag_target.sv
// tb_i2c_diag_target: directed frame table plus hand-written repeated-start, partial, glitch and reset sequences
module tb_i2c_diag_target;
    localparam int Q = 10;
    typedef struct {
        logic [7:0]  addr;
        int          n;
        logic [31:0] d;
        logic [4:0]  ack;
        int          nv;
        int          ne;
        logic [7:0]  page;
        logic [15:0] val;
        logic [15:0] fc;
        logic [15:0] ec;
    } vec_t;
    logic        clk = 1'b0, ext_reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic        sda_oe, rx_valid, frame_err, busy, sda_bus;
    logic [7:0]  rx_page;
    logic [15:0] rx_value, frame_cnt, err_cnt;
    int          n_chk = 0, n_fail = 0, n_v = 0, n_e = 0, n_oe = 0;
    vec_t        vecs[8];
    vec_t        gv;
    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rx_valid) n_v++;
        if (frame_err) n_e++;
        if (sda_oe) n_oe++;
    end
    i2c_diag_target dut (
        .clk(clk), .ext_reset(ext_reset), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .rx_valid(rx_valid), .rx_page(rx_page), .rx_value(rx_value),
        .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic q();
        repeat (Q) @(posedge clk);
        #1;
    endtask
    task automatic i2c_start();
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
    endtask
    task automatic i2c_stop();
        sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
    endtask
    task automatic send_bit(input logic b, input logic g, output logic rd);
        sda_m = b;
        if (g) begin
            @(posedge clk); #1 scl_m = 1'b1;
            @(posedge clk); #1 scl_m = 1'b0;
        end
        q(); scl_m = 1'b1; q();
        rd = sda_bus;
        if (g) begin
            scl_m = 1'b0;
            @(posedge clk); #1 scl_m = 1'b1;
        end
        q(); scl_m = 1'b0; q();
    endtask
    task automatic send_byte(input logic [7:0] b, input logic g, output logic ack);
        logic rd;
        for (int i = 7; i >= 0; i--) send_bit(b[i], g, rd);
        send_bit(1'b1, g, rd);
        ack = ~rd;
    endtask
    task automatic apply(input string nm, input vec_t v, input logic g);
        int         v0, e0, o0;
        logic       a;
        logic [4:0] acks;
        v0 = n_v; e0 = n_e; o0 = n_oe; acks = '0;
        i2c_start();
        send_byte(v.addr, g, a);
        acks[0] = a;
        chk({nm, " busy_mid"}, busy, 1);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.d[31-8*i -: 8], g, a);
            acks[i+1] = a;
        end
        i2c_stop();
        chk({nm, " acks"}, acks, v.ack);
        chk({nm, " valid_pulses"}, n_v - v0, v.nv);
        chk({nm, " err_pulses"}, n_e - e0, v.ne);
        chk({nm, " oe_used"}, n_oe != o0, v.ack != 0);
        chk({nm, " rx_page"}, rx_page, v.page);
        chk({nm, " rx_value"}, rx_value, v.val);
        chk({nm, " frame_cnt"}, frame_cnt, v.fc);
        chk({nm, " err_cnt"}, err_cnt, v.ec);
        chk({nm, " busy_end"}, busy, 0);
    endtask
    initial begin
        logic a, rd, seen;
        int   v0, e0;
        vecs[0] = '{8'hBA, 3, 32'h07123400, 5'b01111, 1, 0, 8'h07, 16'h1234, 16'd1, 16'd0};
        vecs[1] = '{8'hB8, 3, 32'h11223300, 5'b00000, 0, 0, 8'h07, 16'h1234, 16'd1, 16'd0};
        vecs[2] = '{8'hBA, 2, 32'h55660000, 5'b00111, 0, 1, 8'h07, 16'h1234, 16'd1, 16'd1};
        vecs[3] = '{8'hBA, 4, 32'h01020304, 5'b01111, 0, 1, 8'h07, 16'h1234, 16'd1, 16'd2};
        vecs[4] = '{8'hBB, 0, 32'h00000000, 5'b00000, 0, 0, 8'h07, 16'h1234, 16'd1, 16'd2};
        vecs[5] = '{8'hBA, 0, 32'h00000000, 5'b00001, 0, 1, 8'h07, 16'h1234, 16'd1, 16'd3};
        vecs[6] = '{8'hBA, 3, 32'hFF000100, 5'b01111, 1, 0, 8'hFF, 16'h0001, 16'd2, 16'd3};
        vecs[7] = '{8'hBA, 3, 32'h00FFFE00, 5'b01111, 1, 0, 8'h00, 16'hFFFE, 16'd3, 16'd3};
        gv      = '{8'hBA, 3, 32'h3C5AA500, 5'b01111, 1, 0, 8'h3C, 16'h5AA5, 16'd5, 16'd5};
        repeat (3) @(posedge clk);
        #1;
        chk("rst sda_oe", sda_oe, 0);
        chk("rst outputs", {rx_valid, frame_err, busy, rx_page, rx_value}, 0);
        chk("rst counters", {frame_cnt, err_cnt}, 0);
        ext_reset = 1'b1;
        q();
        for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), vecs[i], 1'b0);
        v0 = n_v; e0 = n_e;
        i2c_start();
        send_byte(8'hBA, 1'b0, a);
        send_byte(8'h09, 1'b0, a);
        i2c_start();
        chk("rs err_pulse", n_e - e0, 1);
        chk("rs addr_ack", {a, busy}, 2'b11);
        send_byte(8'hBA, 1'b0, a);
        send_byte(8'h21, 1'b0, a);
        send_byte(8'hAB, 1'b0, a);
        send_byte(8'hCD, 1'b0, a);
        i2c_stop();
        chk("rs valid_pulse", n_v - v0, 1);
        chk("rs frame", {rx_page, rx_value}, 24'h21ABCD);
        chk("rs counters", {frame_cnt, err_cnt}, {16'd4, 16'd4});
        e0 = n_e;
        i2c_start();
        send_byte(8'hBA, 1'b0, a);
        send_bit(1'b1, 1'b0, rd);
        send_bit(1'b0, 1'b0, rd);
        send_bit(1'b1, 1'b0, rd);
        i2c_stop();
        chk("partial err_pulse", n_e - e0, 1);
        chk("partial keep", {rx_page, rx_value, frame_cnt, err_cnt}, {8'h21, 16'hABCD, 16'd4, 16'd5});
        apply("glitch", gv, 1'b1);
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i[0] ? (8'hBA >> i) & 8'h01 : (8'hBA >> i) & 8'h01, 1'b0, rd);
        sda_m = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 * Q && !seen; i++) begin
            @(posedge clk);
            #1 seen = sda_oe;
        end
        chk("rst_ack drive_seen", seen, 1);
        #2 ext_reset = 1'b0;
        #1;
        chk("rst_ack sda_oe", sda_oe, 0);
        chk("rst_ack outputs", {rx_valid, frame_err, busy, rx_page, rx_value}, 0);
        chk("rst_ack counters", {frame_cnt, err_cnt}, 0);
        v0 = n_v; e0 = n_e;
        repeat (3) @(posedge clk);
        #1 ext_reset = 1'b1;
        q();
        i2c_stop();
        chk("rst_ack no_pulses", (n_v - v0) + (n_e - e0), 0);
        chk("rst_ack idle", {busy, frame_cnt, err_cnt}, 0);
        apply("post_rst", vecs[0], 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
